// File: rtl/elevator_pkg.sv
// Shared constants, state encoding and floor helpers for the three-floor elevator controller.
package elevator_pkg;

    localparam logic [1:0] MOTOR_OFF  = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b10;
    localparam logic [1:0] MOTOR_DOWN = 2'b11;

    localparam logic [2:0] F1 = 3'b001;
    localparam logic [2:0] F2 = 3'b010;
    localparam logic [2:0] F3 = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    function automatic logic [2:0] floor_up(input logic [2:0] f);
        return (f == F3) ? F3 : (f << 1);
    endfunction

    function automatic logic [2:0] floor_down(input logic [2:0] f);
        return (f == F1) ? F1 : (f >> 1);
    endfunction

    // Masks of floors strictly above / below a one-hot position.
    function automatic logic [2:0] aboveMask(input logic [2:0] f);
        return ~(f | (f - 3'd1));
    endfunction

    function automatic logic [2:0] belowMask(input logic [2:0] f);
        return f - 3'd1;
    endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Loadable down-counter: loads TICKS, counts down to zero and holds; expire flags the final tick.
module elevator_tick_timer
    import elevator_pkg::*;
#(
    parameter int TICKS = 3,
    parameter int W     = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    output logic [W-1:0] value,
    output logic         expire
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            value <= '0;
        end else if (load) begin
            value <= W'(TICKS);
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign expire = (value == W'(1));

endmodule

// File: rtl/elevator_dispatch.sv
// SCAN-order dispatcher for a three-floor car: call latch, direction choice, timed travel and door dwell.
module elevator_dispatch
    import elevator_pkg::*;
#(
    parameter int FLOOR_TICKS = 3,
    parameter int DOOR_TICKS  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:1] inDoorButtons,
    input  logic [3:1] outDoorButtons,
    output logic [1:0] motor,
    output logic       doorState,
    output logic [3:1] currentFloor,
    output logic [3:1] pending,
    output logic       dirUp
);

    localparam int MAXT = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    state_t        state, stateNext;
    logic          dirNext;
    logic [3:1]    floorNext, pendingNext, calls;
    logic          travelLoad, dwellLoad, travelExpire, dwellExpire;
    logic [CW-1:0] travelValue, dwellValue;
    logic          atCur, above, below, endUp, endDown, atEnd, shiftNow;
    logic          travelDone, dwellDone;

    elevator_tick_timer #(.TICKS(FLOOR_TICKS), .W(CW)) travelTimer (
        .CLK    (CLK),
        .RST    (RST),
        .load   (travelLoad),
        .value  (travelValue),
        .expire (travelExpire)
    );

    elevator_tick_timer #(.TICKS(DOOR_TICKS), .W(CW)) dwellTimer (
        .CLK    (CLK),
        .RST    (RST),
        .load   (dwellLoad),
        .value  (dwellValue),
        .expire (dwellExpire)
    );

    // A zero count while busy would otherwise stall the FSM, so treat it as done.
    assign travelDone = travelExpire || (travelValue == '0);
    assign dwellDone  = dwellExpire || (dwellValue == '0);

    always_comb begin
        calls      = pending | inDoorButtons | outDoorButtons;
        atCur      = |(pending & currentFloor);
        above      = |(pending & aboveMask(currentFloor));
        below      = |(pending & belowMask(currentFloor));
        endUp      = (currentFloor == F3);
        endDown    = (currentFloor == F1);
        stateNext  = state;
        dirNext    = dirUp;
        floorNext  = currentFloor;
        travelLoad = 1'b0;
        dwellLoad  = 1'b0;
        shiftNow   = 1'b0;

        unique case (state)
            IDLE: begin
                if (atCur) begin
                    stateNext = DOOR;
                    dwellLoad = 1'b1;
                end else if (above && (dirUp || !below)) begin
                    stateNext  = MOVE;
                    dirNext    = 1'b1;
                    travelLoad = 1'b1;
                end else if (below) begin
                    stateNext  = MOVE;
                    dirNext    = 1'b0;
                    travelLoad = 1'b1;
                end
            end
            MOVE: begin
                if (travelDone) begin
                    if (atCur) begin
                        stateNext = DOOR;
                        dwellLoad = 1'b1;
                    end else if (dirUp ? endUp : endDown) begin
                        stateNext = IDLE;
                    end else begin
                        travelLoad = 1'b1;
                    end
                end
            end
            DOOR: begin
                if (|((inDoorButtons | outDoorButtons) & currentFloor)) begin
                    dwellLoad = 1'b1;
                end else if (dwellDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // The floor display advances on the last motor cycle of each hop, so the
        // arrival decision one cycle later sees the new floor.
        atEnd = dirNext ? endUp : endDown;
        if (stateNext == MOVE) begin
            shiftNow = (travelLoad && (FLOOR_TICKS == 1)) ||
                       ((state == MOVE) && (FLOOR_TICKS >= 2) && (travelValue == CW'(2)));
        end
        if (shiftNow) begin
            if (atEnd) begin
                stateNext  = IDLE;
                travelLoad = 1'b0;
            end else begin
                floorNext = dirNext ? floor_up(currentFloor) : floor_down(currentFloor);
            end
        end

        pendingNext = calls & ~((stateNext == DOOR) ? currentFloor : 3'b000);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            motor        <= MOTOR_OFF;
            doorState    <= 1'b0;
            currentFloor <= F1;
            pending      <= '0;
            dirUp        <= 1'b1;
        end else begin
            state        <= stateNext;
            motor        <= (stateNext == MOVE) ? (dirNext ? MOTOR_UP : MOTOR_DOWN) : MOTOR_OFF;
            doorState    <= (stateNext == DOOR);
            currentFloor <= floorNext;
            pending      <= pendingNext;
            dirUp        <= dirNext;
        end
    end

endmodule

// File: tb/tb_elevator_dispatch.sv
// Bench for elevator_dispatch: directed scenarios plus random presses against an integer-floor reference model.
module tb_elevator_dispatch;

    localparam int FT = 3;
    localparam int DT = 3;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:1] inDoorButtons = '0;
    logic [3:1] outDoorButtons = '0;
    logic [1:0] motor;
    logic       doorState;
    logic [3:1] currentFloor;
    logic [3:1] pending;
    logic       dirUp;

    int tests = 0;
    int fails = 0;

    // Reference model state: floor as an integer 1..3, hop progress counted upward.
    int       mFloor;
    bit [3:1] mPend;
    int       mMode;
    bit       mDir;
    int       mHop;
    int       mDoor;

    elevator_dispatch #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .inDoorButtons  (inDoorButtons),
        .outDoorButtons (outDoorButtons),
        .motor          (motor),
        .doorState      (doorState),
        .currentFloor   (currentFloor),
        .pending        (pending),
        .dirUp          (dirUp)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit [3:1] btn);
        bit above, below;
        int nextMode;
        if (r) begin
            mFloor = 1; mPend = '0; mMode = M_IDLE; mDir = 1'b1; mHop = 0; mDoor = 0;
            return;
        end
        above = 1'b0;
        below = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            if (mPend[f] && f > mFloor) above = 1'b1;
            if (mPend[f] && f < mFloor) below = 1'b1;
        end
        nextMode = mMode;
        case (mMode)
            M_IDLE: begin
                if (mPend[mFloor]) begin
                    nextMode = M_DOOR; mDoor = DT;
                end else if (above && (mDir || !below)) begin
                    nextMode = M_MOVE; mDir = 1'b1; mHop = 1;
                end else if (below) begin
                    nextMode = M_MOVE; mDir = 1'b0; mHop = 1;
                end
            end
            M_MOVE: begin
                if (mHop == FT) begin
                    if (mPend[mFloor]) begin
                        nextMode = M_DOOR; mDoor = DT;
                    end else begin
                        mHop = 1;
                    end
                end else begin
                    mHop++;
                end
            end
            default: begin
                if (btn[mFloor]) mDoor = DT;
                else if (mDoor == 1) nextMode = M_IDLE;
                else mDoor--;
            end
        endcase
        if (nextMode == M_MOVE && mHop == FT) begin
            if (mDir && mFloor < 3) mFloor++;
            else if (!mDir && mFloor > 1) mFloor--;
        end
        mPend = mPend | btn;
        if (nextMode == M_DOOR) mPend[mFloor] = 1'b0;
        mMode = nextMode;
    endtask

    task automatic compareAll();
        logic [1:0] em;
        logic [3:1] ef;
        em = (mMode == M_MOVE) ? (mDir ? 2'b10 : 2'b11) : 2'b00;
        ef = 3'(1 << (mFloor - 1));
        checkVal("motor", {6'd0, motor}, {6'd0, em});
        checkVal("door", {7'd0, doorState}, {7'd0, mMode == M_DOOR});
        checkVal("floor", {5'd0, currentFloor}, {5'd0, ef});
        checkVal("pending", {5'd0, pending}, {5'd0, mPend});
        checkVal("dirUp", {7'd0, dirUp}, {7'd0, mDir});
        checkVal("motorLegal", {7'd0, motor != 2'b01}, 8'd1);
        checkVal("motorDoorExcl", {7'd0, !(motor != 2'b00 && doorState)}, 8'd1);
        checkVal("floorOneHot", {7'd0, $onehot(currentFloor)}, 8'd1);
    endtask

    task automatic tick(input logic [3:1] ib, input logic [3:1] ob, input bit r);
        inDoorButtons  = ib;
        outDoorButtons = ob;
        RST            = r;
        @(posedge CLK);
        modelStep(r, ib | ob);
        @(negedge CLK);
        compareAll();
    endtask

    task automatic idleTicks(input int n);
        for (int i = 0; i < n; i++) tick('0, '0, 1'b0);
    endtask

    initial begin
        int mc, dc, waited;
        logic [3:1] ib, ob, holdIb, holdOb;
        int holdLeft;
        bit r;

        @(negedge CLK);
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b1);
        checkVal("rstMotor", {6'd0, motor}, 8'd0);
        checkVal("rstDoor", {7'd0, doorState}, 8'd0);
        checkVal("rstFloor", {5'd0, currentFloor}, 8'h01);
        checkVal("rstPending", {5'd0, pending}, 8'd0);
        checkVal("rstDirUp", {7'd0, dirUp}, 8'd1);

        // Hall call to F3 from F1: two floors of travel then one dwell.
        tick('0, 3'b100, 1'b0);
        checkVal("s1PendLatched", {5'd0, pending}, 8'h04);
        mc = 0; dc = 0;
        for (int i = 0; i < 15; i++) begin
            tick('0, '0, 1'b0);
            if (motor != 2'b00) mc++;
            if (doorState) dc++;
        end
        checkVal("s1MotorCycles", 8'(mc), 8'd6);
        checkVal("s1DoorCycles", 8'(dc), 8'd3);
        checkVal("s1Floor", {5'd0, currentFloor}, 8'h04);
        checkVal("s1Pending", {5'd0, pending}, 8'd0);

        tick('0, 3'b001, 1'b0);
        idleTicks(20);
        checkVal("backAtF1", {5'd0, currentFloor}, 8'h01);

        // Car call at the current floor: door only.
        tick(3'b001, '0, 1'b0);
        mc = 0; dc = 0;
        for (int i = 0; i < 8; i++) begin
            tick('0, '0, 1'b0);
            if (motor != 2'b00) mc++;
            if (doorState) dc++;
        end
        checkVal("s2DoorCycles", 8'(dc), 8'd3);
        checkVal("s2MotorCycles", 8'(mc), 8'd0);

        // Two simultaneous calls ahead: intermediate stop then continue.
        tick('0, 3'b110, 1'b0);
        idleTicks(25);
        checkVal("s3Floor", {5'd0, currentFloor}, 8'h04);
        tick('0, 3'b001, 1'b0);
        idleTicks(20);

        // F1 call raised behind the car at the F2 arrival.
        tick('0, 3'b100, 1'b0);
        waited = 0;
        while (currentFloor != 3'b010 && waited < 20) begin
            tick('0, '0, 1'b0);
            waited++;
        end
        checkVal("s4ReachF2", {7'd0, currentFloor == 3'b010}, 8'd1);
        tick('0, 3'b001, 1'b0);
        idleTicks(30);
        checkVal("s4EndFloor", {5'd0, currentFloor}, 8'h01);
        checkVal("s4DirDown", {7'd0, dirUp}, 8'd0);

        // Held car call at F2 during the dwell.
        tick(3'b010, '0, 1'b0);
        waited = 0;
        while (!doorState && waited < 20) begin
            tick('0, '0, 1'b0);
            waited++;
        end
        checkVal("s5DoorOpen", {7'd0, doorState}, 8'd1);
        for (int i = 0; i < 6; i++) begin
            tick(3'b010, '0, 1'b0);
            checkVal("s5HoldPend2", {7'd0, pending[2]}, 8'd0);
            checkVal("s5HoldDoor", {7'd0, doorState}, 8'd1);
        end
        idleTicks(10);

        // Reset while moving from F1 toward F2.
        tick('0, '0, 1'b1);
        tick('0, 3'b010, 1'b0);
        tick('0, '0, 1'b0);
        tick('0, '0, 1'b0);
        checkVal("s6Moving", {6'd0, motor}, 8'h02);
        tick('0, '0, 1'b1);
        checkVal("s6Motor", {6'd0, motor}, 8'd0);
        checkVal("s6Floor", {5'd0, currentFloor}, 8'h01);
        checkVal("s6Pending", {5'd0, pending}, 8'd0);
        checkVal("s6Door", {7'd0, doorState}, 8'd0);

        // Random presses, occasional holds and resets.
        holdLeft = 0;
        holdIb = '0;
        holdOb = '0;
        for (int c = 0; c < 3000; c++) begin
            ib = '0;
            ob = '0;
            r  = ($urandom_range(399) == 0);
            if (holdLeft > 0) begin
                ib = holdIb;
                ob = holdOb;
                holdLeft--;
            end else if ($urandom_range(7) == 0) begin
                ib = 3'($urandom_range(7));
                ob = 3'($urandom_range(7));
                if ($urandom_range(3) == 0) begin
                    holdIb   = ib;
                    holdOb   = ob;
                    holdLeft = $urandom_range(8, 1);
                end
            end
            tick(ib, ob, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
